hazard_forward_unit: RTL and testbench

- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Generates the 2-bit select codes consumed by the EX-stage operand hazard muxes.
- Generates the pipeline stall and flush controls.
- Keeps internal shadow copies of EX/MEM/WB destination-register state, including load and multiply tags.
- Sequences a multi-cycle multiplier occupancy FSM that holds the EX stage.

---
 rtl/hazard_forward_unit.sv | 182 ++++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Tracks shadow EX/MEM/WB destination state to produce EX operand forwarding
// selects, load-use and multiplier stalls, and IF/ID and ID/EX flushes.
// Optional feature macro: BRANCH_FWD_EN (ID-stage branch operand forwarding
// and branch stall); the default build leaves it out.
module hazard_forward_unit #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] writereg_d,
    input  logic       regwrite_d,
    input  logic       memtoreg_d,
    input  logic       mul_d,
    input  logic       branch_d,
    input  logic       branch_taken_d,
`ifdef BRANCH_FWD_EN
    output logic       forward_ad,
    output logic       forward_bd,
`endif
    output logic [1:0] forward_ae,
    output logic [1:0] forward_be,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       flush_d,
    output logic       flush_e,
    output logic       mdu_busy
);

    localparam int unsigned CntW = $clog2(MUL_LAT) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MUL_LAT - 1);

    typedef enum logic {StIdle, StBusy} mdu_state_e;

    // Shadow pipeline state
    logic [4:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d, writereg_e_q, writereg_e_d;
    logic       regwrite_e_q, regwrite_e_d, memtoreg_e_q, memtoreg_e_d;
    logic       mul_e_q, mul_e_d;
    logic [4:0] writereg_m_q, writereg_m_d, writereg_w_q, writereg_w_d;
    logic       regwrite_m_q, regwrite_m_d, regwrite_w_q, regwrite_w_d;
    logic       memtoreg_m_q, memtoreg_m_d;

    mdu_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic mdu_stall, lwstall, branchstall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       rw_m,
                                           input logic [4:0] wr_m,
                                           input logic       rw_w,
                                           input logic [4:0] wr_w);
        if (src != '0 && rw_m && wr_m == src) begin
            return 2'b10;
        end else if (src != '0 && rw_w && wr_w == src) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // Hazard detection, stall/flush and forwarding select decode
    always_comb begin
        mdu_stall = mul_e_q && (cnt_q < CntMax);
        // A mul that also carries a load tag is treated purely as a mul
        lwstall = memtoreg_e_q && !mul_e_q && (writereg_e_q != '0) &&
                  ((writereg_e_q == rs_d) || (writereg_e_q == rt_d));
`ifdef BRANCH_FWD_EN
        branchstall = branch_d &&
            ((regwrite_e_q && (writereg_e_q != '0) &&
              ((writereg_e_q == rs_d) || (writereg_e_q == rt_d))) ||
             (memtoreg_m_q && ((writereg_m_q == rs_d) || (writereg_m_q == rt_d))));
        forward_ad = (rs_d != '0) && regwrite_m_q && (writereg_m_q == rs_d);
        forward_bd = (rt_d != '0) && regwrite_m_q && (writereg_m_q == rt_d);
`else
        branchstall = 1'b0;
`endif
        stall_e = mdu_stall;
        stall_f = lwstall | mdu_stall | branchstall;
        stall_d = stall_f;
        // The multiplier hold wins: EX is never bubbled while it is held
        flush_e = (lwstall | branchstall) & ~stall_e;
        // Reset gate keeps every output low while reset is asserted
        flush_d = branch_taken_d & ~stall_d & ~reset;
        forward_ae = fwd_sel(rs_e_q, regwrite_m_q, writereg_m_q, regwrite_w_q, writereg_w_q);
        forward_be = fwd_sel(rt_e_q, regwrite_m_q, writereg_m_q, regwrite_w_q, writereg_w_q);
        mdu_busy = (state_q == StBusy);
    end

    // Shadow register next state: EX hold wins over EX bubble
    always_comb begin
        rs_e_d       = rs_d;
        rt_e_d       = rt_d;
        writereg_e_d = writereg_d;
        regwrite_e_d = regwrite_d;
        memtoreg_e_d = memtoreg_d;
        mul_e_d      = mul_d;
        writereg_m_d = writereg_e_q;
        regwrite_m_d = regwrite_e_q;
        memtoreg_m_d = memtoreg_e_q;
        writereg_w_d = writereg_m_q;
        regwrite_w_d = regwrite_m_q;
        if (stall_e) begin
            rs_e_d       = rs_e_q;
            rt_e_d       = rt_e_q;
            writereg_e_d = writereg_e_q;
            regwrite_e_d = regwrite_e_q;
            memtoreg_e_d = memtoreg_e_q;
            mul_e_d      = mul_e_q;
            writereg_m_d = '0;
            regwrite_m_d = 1'b0;
            memtoreg_m_d = 1'b0;
        end else if (flush_e) begin
            rs_e_d       = '0;
            rt_e_d       = '0;
            writereg_e_d = '0;
            regwrite_e_d = 1'b0;
            memtoreg_e_d = 1'b0;
            mul_e_d      = 1'b0;
        end
    end

    // Multiplier occupancy FSM next state
    always_comb begin
        if (mdu_stall) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StBusy;
        end else begin
            cnt_d   = '0;
            state_d = StIdle;
        end
    end

    // Shadow pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_e_q       <= '0;
            rt_e_q       <= '0;
            writereg_e_q <= '0;
            regwrite_e_q <= 1'b0;
            memtoreg_e_q <= 1'b0;
            mul_e_q      <= 1'b0;
            writereg_m_q <= '0;
            regwrite_m_q <= 1'b0;
            memtoreg_m_q <= 1'b0;
            writereg_w_q <= '0;
            regwrite_w_q <= 1'b0;
        end else begin
            rs_e_q       <= rs_e_d;
            rt_e_q       <= rt_e_d;
            writereg_e_q <= writereg_e_d;
            regwrite_e_q <= regwrite_e_d;
            memtoreg_e_q <= memtoreg_e_d;
            mul_e_q      <= mul_e_d;
            writereg_m_q <= writereg_m_d;
            regwrite_m_q <= regwrite_m_d;
            memtoreg_m_q <= memtoreg_m_d;
            writereg_w_q <= writereg_w_d;
            regwrite_w_q <= regwrite_w_d;
        end
    end

    // Multiplier FSM state and counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifndef BRANCH_FWD_EN
    // Branch forwarding is absent, so the branch and MEM load tags go unused
    logic unused_branch;
    assign unused_branch = branch_d ^ memtoreg_m_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit (default build, MUL_LAT = 4).
// The driver applies one ID-stage instruction per cycle just after the rising
// edge and queues the hand-computed expected outputs; the monitor pops and
// compares on every falling edge.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rs_d = '0, rt_d = '0, writereg_d = '0;
    logic       regwrite_d = 1'b0, memtoreg_d = 1'b0, mul_d = 1'b0;
    logic       branch_d = 1'b0, branch_taken_d = 1'b0;
    logic [1:0] forward_ae, forward_be;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, mdu_busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    hazard_forward_unit #(.MUL_LAT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .rs_d           (rs_d),
        .rt_d           (rt_d),
        .writereg_d     (writereg_d),
        .regwrite_d     (regwrite_d),
        .memtoreg_d     (memtoreg_d),
        .mul_d          (mul_d),
        .branch_d       (branch_d),
        .branch_taken_d (branch_taken_d),
        .forward_ae     (forward_ae),
        .forward_be     (forward_be),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .mdu_busy       (mdu_busy)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {fa, fb, sf, sd, se, fd, fe, busy}
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] wr, input logic rw, input logic mtr,
                        input logic mul, input logic br, input logic bt,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic sf, input logic sd, input logic se,
                        input logic fd, input logic fe, input logic bz,
                        input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = r;
        rs_d           = rs;
        rt_d           = rt;
        writereg_d     = wr;
        regwrite_d     = rw;
        memtoreg_d     = mtr;
        mul_d          = mul;
        branch_d       = br;
        branch_taken_d = bt;
        e.exp  = {fa, fb, sf, sd, se, fd, fe, bz};
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every cycle that has a queued expectation
    always @(negedge clk) begin
        exp_t e;
        logic [9:0] act;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act = {forward_ae, forward_be, stall_f, stall_d, stall_e, flush_d, flush_e,
                   mdu_busy};
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %b expected %b (fa fb sf sd se fd fe busy)",
                         e.name, act, e.exp);
            end
        end
    end

    initial begin
        //   r  rs rt wr rw mt mu br bt  fa     fb     sf sd se fd fe bz
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "reset_hold");
        step(0, 2, 3, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "add1_issue");
        step(0, 1, 2, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "add3_issue");
        step(0, 7, 8, 6, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, "fwd_mem_a");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "gap_nop");
        step(0, 6, 6, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "add9_issue");
        step(0, 1, 2, 0, 1, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, "fwd_wb_ab");
        step(0, 0, 0, 4, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "zero_src_issue");
        step(0, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "no_fwd_r0");
        step(0, 2, 3, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "add5b_issue");
        step(0, 5, 5, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "add7_issue");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, "mem_over_wb");
        // Load-use
        step(0, 1, 0, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "lw_issue");
        step(0, 3, 2, 4, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0, 1, 0, "lwstall");
        step(0, 3, 2, 4, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "lwstall_release");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, "lw_fwd_wb");
        // Multiply occupancy
        step(0, 1, 2, 8, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "mul_issue");
        step(0, 8, 3, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 0, 0, "mul_stall1");
        step(0, 8, 3, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 0, 1, "mul_stall2");
        step(0, 8, 3, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 0, 1, "mul_stall3");
        step(0, 8, 3, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, "mul_release");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, "mul_fwd_mem");
        // Branch flush
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, "branch_flush");
        step(0, 1, 0, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "lw2_issue");
        step(0, 2, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 1, 0, 0, 1, 0, "branch_lwstall");
        step(0, 2, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, "branch_release");
        // Reset in the middle of a multiply
        step(0, 1, 2, 8, 1, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, "mul2_issue");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 0, 0, "mul2_stall1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 0, 1, "mul2_stall2");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "reset_mid_mul");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "post_reset1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, "post_reset2");

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
